cfg_slv: RTL
============

# cfg_slv

Configuration-port responder inside `cbc_dig`; far end of the 8N1 serial link driven by the config master.
- Deserialises a 3-byte command from `RX_C` into a 24-bit word and hands it to the digital core with a one-cycle strobe.
- Serialises the core's 16-bit response back on `TX_C` as 2 bytes.
- Receive and transmit run full-duplex and independently.

## Interface
- `BAUD_DIV`, 542: clk cycles per bit (500 MHz / ~921.6 kbaud); must be ≥ 8.
- `TO_BITS`, 32: inter-byte timeout, in bit periods.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `RX_C`  in  1  serial command input, idle high, asynchronous to `clk`.
- `TX_C`  out  1  serial response output, idle high.
- `cmd_data`  out  24  last complete command; first received byte is in [23:16].
- `cmd_rdy`  out  1  one-cycle strobe: `cmd_data` just updated.
- `frm_err`  out  1  one-cycle strobe: stop bit sampled low.
- `rsp_data`  in  16  response word; sampled only when `rsp_send` is accepted.
- `rsp_send`  in  1  request to transmit `rsp_data`.
- `tx_busy`  out  1  high while a response is being transmitted.

## Operation
- **RX synchroniser:** 2-flop synchroniser on `RX_C`, both flops reset to 1. All receive decisions use the synchronised signal.
- **RX states:** IDLE, START, DATA, STOP.
  - IDLE → START on a 1→0 transition of the synchronised line.
  - START waits BAUD_DIV/2 cycles (integer division), then re-samples. If the line is high, the event is a false start and the FSM returns to IDLE with nothing recorded. Otherwise → DATA.
  - DATA samples 8 bits, LSB first, one every BAUD_DIV cycles.
  - STOP samples once more after BAUD_DIV cycles.
    - Stop bit = 1: byte accepted.
    - Stop bit = 0: pulse `frm_err`, discard the byte, clear the byte count.
  - STOP → IDLE in both cases.
- **Byte assembly:**
  - 2-bit byte count 0..2. Accepted bytes shift into a 24-bit holding register.
  - The third accepted byte copies the holding register to `cmd_data`, pulses `cmd_rdy` and clears the count.
  - `cmd_data` holds its value until the next complete command.
- **Inter-byte timeout:** while the count is 1 or 2 and RX is IDLE, a counter runs. If it reaches TO_BITS·BAUD_DIV cycles, the count clears and the partial command is dropped. The counter is cleared by any start detect.
- **TX states:** IDLE, START, DATA, STOP, with a byte index 0/1.
  - `rsp_send` while `tx_busy`=0 latches `rsp_data` and moves IDLE → START.
  - Byte 0 is [15:8], byte 1 is [7:0]. Each byte goes out as start bit 0, 8 data bits LSB first, stop bit 1, each bit held BAUD_DIV cycles.
  - The stop bit of byte 0 is followed directly by the start bit of byte 1, with no idle gap.
- **Ignored requests:** `rsp_send` while `tx_busy`=1 is ignored; no queueing.
- **Reset values:** `TX_C`=1, `cmd_data`=0, `cmd_rdy`=0, `frm_err`=0, `tx_busy`=0. Both FSMs return to IDLE and all counters clear.
- **Reset mid-frame:** `TX_C` is high on the first edge with `rst_n`=0, and any partial RX/TX frame is lost.

## Timing
- **Accept → line:** `rsp_send` accepted at edge N gives `tx_busy`=1 and `TX_C`=0 from edge N+1.
- **TX frame length:** a response occupies exactly 20·BAUD_DIV cycles on `TX_C`. `tx_busy` falls at the end of the second stop bit. A new `rsp_send` is accepted in that same cycle.
- **RX start detect:** 2 cycles after the physical falling edge (synchroniser delay).
- **RX sample points:** the start bit is checked BAUD_DIV/2 cycles after start detect. Each following bit is sampled BAUD_DIV cycles after the previous sample.
- **Strobes:** `cmd_rdy` and `frm_err` assert for exactly one cycle, on the edge after the stop-bit sample.
- **Back-to-back RX:** a new start may be detected in the cycle after the stop-bit sample.
- **Simultaneous events:** RX completion during TX activity, and vice versa, have no interaction. A timeout expiring in the same cycle as a start detect: the start wins and the count is kept.

## Structure
- **Shared package `cfg_pkg`:** `CMD_W`=24, `RSP_W`=16, the RX/TX state enums, and the default `BAUD_DIV`.
- **Sub-module `uart_rx_byte`:** synchroniser + RX FSM. Outputs are `rx_byte[7:0]`, `rx_vld` and `rx_ferr`, all one-cycle.
- **Top-level logic:** byte assembly, timeout and the TX FSM live in `cfg_slv` itself.

## Test plan
1. **Reset:** hold `rst_n`=0 for 4 cycles while `RX_C` toggles → `TX_C`=1, `cmd_rdy`/`frm_err`/`tx_busy`=0 and `cmd_data`=0 throughout.
2. **Command receive:** config master sends 24'hA53C0F → exactly one `cmd_rdy` pulse, with `cmd_data`=24'hA53C0F.
3. **Response transmit:** `rsp_send` with 16'hBEEF.
   - `TX_C` carries bytes 0xBE then 0xEF.
   - `tx_busy` stays high for exactly 20·BAUD_DIV cycles.
   - The master reports `rsp`=16'hBEEF with `rsp_rdy`.
   - A second `rsp_send` 10 cycles in is ignored.
4. **Framing error:** send byte 0x55 with stop bit 0 → one `frm_err` pulse and no `cmd_rdy`. A following 24'h123456 decodes correctly.
5. **Timeout:** send one byte 0xFF, idle (TO_BITS+1)·BAUD_DIV cycles, then send 24'h112233 → `cmd_data`=24'h112233.
6. **Glitch and full duplex:**
   - A `RX_C` low pulse of BAUD_DIV/4 cycles produces no byte and no strobe.
   - A command received during an active response transmit yields the correct `cmd_data`, and `TX_C` is bit-exact.

Source files
------------

// File: rtl/cfg_pkg.sv
`default_nettype none
// cfg_pkg: widths, state encodings and default bit period shared by the cfg_slv slice.
// rev 1.0
package cfg_pkg;
  localparam int CMD_W        = 24;
  localparam int RSP_W        = 16;
  localparam int DEF_BAUD_DIV = 542;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;
endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// uart_rx_byte: RX line synchroniser and 8N1 byte receiver with one-cycle byte/error strobes.
// rev 1.0
module uart_rx_byte
  import cfg_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       rx_ferr,
  output logic       rx_idle,
  output logic       rx_start
);
  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  logic          sync1;
  logic          sync2;
  logic          line_q;
  rx_state_t     state;
  rx_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          fall;
  logic          tick;
  logic          half_tick;

  assign fall      = line_q & ~sync2;
  assign tick      = (cnt == BIT_LAST);
  assign half_tick = (cnt == HALF_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      line_q  <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      sync1   <= rx_in;
      sync2   <= sync1;
      line_q  <= sync2;
      state   <= state_nxt;
      // bit timer restarts on every state change and at each full bit period
      cnt     <= ((state == RX_IDLE) || (state_nxt != state) || tick) ? '0 : cnt + 1'b1;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      if ((state == RX_DATA) && tick) begin
        shreg   <= {sync2, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if ((state == RX_STOP) && tick) begin
        rx_vld  <= sync2;
        rx_ferr <= ~sync2;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (fall) state_nxt = RX_START;
      RX_START: if (half_tick) state_nxt = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && (bit_idx == 3'd7)) state_nxt = RX_STOP;
      RX_STOP:  if (tick) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_idle  = (state == RX_IDLE);
    rx_start = (state == RX_IDLE) & fall;
    rx_byte  = shreg;
  end
endmodule
`default_nettype wire

// File: rtl/cfg_slv.sv
`default_nettype none
// cfg_slv: config-port responder -- 3-byte serial command in, 2-byte serial response out, full duplex.
// rev 1.0
module cfg_slv
  import cfg_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV,
  parameter int TO_BITS  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RX_C,
  output logic             TX_C,
  output logic [CMD_W-1:0] cmd_data,
  output logic             cmd_rdy,
  output logic             frm_err,
  input  logic [RSP_W-1:0] rsp_data,
  input  logic             rsp_send,
  output logic             tx_busy
);
  localparam int            CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);
  localparam int            TO_CYC   = TO_BITS * BAUD_DIV;
  localparam int            TW       = $clog2(TO_CYC);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);

  logic [7:0]       rx_byte;
  logic             rx_vld;
  logic             rx_ferr;
  logic             rx_idle;
  logic             rx_start;
  logic [1:0]       byte_cnt;
  logic [15:0]      hold;
  logic [CMD_W-1:0] hold_nxt;
  logic [TW-1:0]    to_cnt;
  logic             to_run;
  logic             to_expire;

  uart_rx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (RX_C),
    .rx_byte  (rx_byte),
    .rx_vld   (rx_vld),
    .rx_ferr  (rx_ferr),
    .rx_idle  (rx_idle),
    .rx_start (rx_start)
  );

  assign hold_nxt  = {hold, rx_byte};
  // a start detect suppresses the timeout in the same cycle
  assign to_run    = rx_idle & ~rx_start & (byte_cnt != 2'd0);
  assign to_expire = to_run & (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      hold     <= 16'd0;
      cmd_data <= '0;
      cmd_rdy  <= 1'b0;
      frm_err  <= 1'b0;
      to_cnt   <= '0;
    end else begin
      cmd_rdy <= 1'b0;
      frm_err <= rx_ferr;
      to_cnt  <= to_run ? to_cnt + 1'b1 : '0;
      if (rx_vld) begin
        hold <= hold_nxt[15:0];
        if (byte_cnt == 2'd2) begin
          cmd_data <= hold_nxt;
          cmd_rdy  <= 1'b1;
          byte_cnt <= 2'd0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (rx_ferr || to_expire) begin
        byte_cnt <= 2'd0;
      end
    end
  end

  tx_state_t        tx_state;
  tx_state_t        tx_nxt;
  logic [CW-1:0]    tx_cnt;
  logic [2:0]       tx_bit;
  logic             tx_idx;
  logic [RSP_W-1:0] tx_dat;
  logic [7:0]       tx_cur;
  logic             tx_tick;

  assign tx_tick = (tx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_idx   <= 1'b0;
      tx_dat   <= '0;
    end else begin
      tx_state <= tx_nxt;
      tx_cnt   <= ((tx_state == TX_IDLE) || tx_tick) ? '0 : tx_cnt + 1'b1;
      if ((tx_state == TX_IDLE) && rsp_send) begin
        tx_dat <= rsp_data;
        tx_idx <= 1'b0;
      end
      if ((tx_state == TX_DATA) && tx_tick) tx_bit <= tx_bit + 1'b1;
      if ((tx_state == TX_STOP) && tx_tick) tx_idx <= ~tx_idx;
    end
  end

  always_comb begin
    tx_nxt = tx_state;
    case (tx_state)
      TX_IDLE:  if (rsp_send) tx_nxt = TX_START;
      TX_START: if (tx_tick) tx_nxt = TX_DATA;
      TX_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_nxt = TX_STOP;
      // first stop bit runs straight into the second start bit
      TX_STOP:  if (tx_tick) tx_nxt = tx_idx ? TX_IDLE : TX_START;
      default:  tx_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_busy = (tx_state != TX_IDLE);
    tx_cur  = tx_idx ? tx_dat[7:0] : tx_dat[15:8];
    case (tx_state)
      TX_START: TX_C = 1'b0;
      TX_DATA:  TX_C = tx_cur[tx_bit];
      default:  TX_C = 1'b1;
    endcase
  end
endmodule
`default_nettype wire
